// File: rtl/calc_pkg.sv
// calc_pkg -- definitions shared by the operand capture, adder and display
// stages of the calculator datapath.
//   OPERAND_WIDTH : width of each operand fed to the 5-bit adder
//   state_t       : operand capture FSM encoding (code 3 is unused)
package calc_pkg;

  localparam int OPERAND_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE_A = 2'd0,
    WAIT_B = 2'd1,
    READY  = 2'd2
  } state_t;

endpackage

// File: rtl/operand_capture_debouncer.sv
// debouncer -- 2-flip-flop synchronizer followed by an optional stability
// filter for a single raw pushbutton.
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   din        : raw button level, asynchronous to clk
//   level      : synchronized (and, when enabled, debounced) level
// Build option: OPERAND_CAPTURE_DEBOUNCE_EN enables the stability filter;
// without it the output is simply the synchronized level.
module debouncer #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level
);

  logic s1_reg;
  logic s2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= din;
      s2_reg <= s1_reg;
    end
  end

`ifdef OPERAND_CAPTURE_DEBOUNCE_EN
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;

  // cnt_reg counts consecutive samples that disagree with the current level;
  // the level flips on the DEB_CYCLES-th such sample, and any agreeing sample
  // restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else if (s2_reg == level_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
      level_reg <= s2_reg;
      cnt_reg   <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign level = level_reg;
`else
  // Stability window has no effect in this build.
  logic unused_deb_cycles;
  assign unused_deb_cycles = (DEB_CYCLES != 0);

  assign level = s2_reg;
`endif

endmodule

// File: rtl/operand_capture.sv
// operand_capture -- captures two operands from switches with a load button
// and presents them to the downstream adder.
//   clk       : clock, all state on rising edge
//   rst_n     : asynchronous active-low reset
//   sw        : raw operand switches (asynchronous)
//   btn_load  : raw load button, active-high, may bounce
//   btn_clear : raw clear button, active-high
//   a, b      : captured operands
//   ready     : high while both a and b hold captured values
//   state     : FSM state code (0 IDLE_A, 1 WAIT_B, 2 READY)
// Build option: OPERAND_CAPTURE_DEBOUNCE_EN enables load button debouncing.
module operand_capture
  import calc_pkg::*;
#(
  parameter int WIDTH      = OPERAND_WIDTH,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [1:0]       state
);

  logic [WIDTH-1:0] sw_s1_reg;
  logic [WIDTH-1:0] sw_s2_reg;
  logic             clr_s1_reg;
  logic             clr_s2_reg;
  logic             load_level;
  logic             load_level_d_reg;
  logic             load_pulse_reg;
  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             ready_reg;

  // Independent per-bit synchronizers; switches are quasi-static so bit skew
  // between lanes only matters while an operand is being changed.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sw_sync
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sw_s1_reg[gi] <= 1'b0;
          sw_s2_reg[gi] <= 1'b0;
        end else begin
          sw_s1_reg[gi] <= sw[gi];
          sw_s2_reg[gi] <= sw_s1_reg[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_s1_reg <= 1'b0;
      clr_s2_reg <= 1'b0;
    end else begin
      clr_s1_reg <= btn_clear;
      clr_s2_reg <= clr_s1_reg;
    end
  end

  debouncer #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_load_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_load),
    .level (load_level)
  );

  // One-cycle pulse on each rising edge of the debounced load level, so a
  // held button produces exactly one capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_level_d_reg <= 1'b0;
      load_pulse_reg   <= 1'b0;
    end else begin
      load_level_d_reg <= load_level;
      load_pulse_reg   <= load_level & ~load_level_d_reg;
    end
  end

  // Clear has priority over a coincident load pulse, which is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE_A;
      a_reg     <= '0;
      b_reg     <= '0;
      ready_reg <= 1'b0;
    end else if (clr_s2_reg) begin
      state_reg <= IDLE_A;
      a_reg     <= '0;
      b_reg     <= '0;
      ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE_A: begin
          if (load_pulse_reg) begin
            a_reg     <= sw_s2_reg;
            state_reg <= WAIT_B;
            ready_reg <= 1'b0;
          end
        end
        WAIT_B: begin
          if (load_pulse_reg) begin
            b_reg     <= sw_s2_reg;
            state_reg <= READY;
            ready_reg <= 1'b1;
          end
        end
        READY: begin
          // A new A operand invalidates the pair; b is kept until replaced.
          if (load_pulse_reg) begin
            a_reg     <= sw_s2_reg;
            state_reg <= WAIT_B;
            ready_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE_A;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign a     = a_reg;
  assign b     = b_reg;
  assign ready = ready_reg;
  assign state = state_reg;

endmodule
